audio_fifo_scheduler: RTL
=========================

Name: audio_fifo_scheduler

Overview:
Shares the single byte-wide write port of the tx FIFO between three frame sources: decimated audio samples, periodic sync markers and on-demand status frames. Each frame is 3 bytes, written LSB first, and is never interleaved with another frame. The block sits in the clk domain, between the already-synchronised sample_reduce done pulse and the tx FIFO. It replaces ad-hoc write logic with priority arbitration, backpressure stalling and overflow accounting.

Parameters:
SYNC_PERIOD, 126, number of accepted samples between sync frames (>=2).
SYNC_WORD, 24'hAAFF00, payload of a sync frame.
STATUS_TAG, 8'h5A, byte 2 of a status frame.
CNT_WIDTH, 16, width of drop_count and frame_count.

Ports:
clk  in  1  system clock.
rst_n  in  1  synchronous, active-low reset.
enable  in  1  1 = new frames may start; 0 = finish the in-flight frame, then stay idle.
sample_valid  in  1  single-cycle pulse; sample_data is valid.
sample_data  in  24  audio sample.
status_req  in  1  single-cycle pulse requesting one status frame.
fifo_full  in  1  FIFO full flag (current state).
fifo_wr_en  out  1  FIFO write strobe (combinational).
fifo_wr_data  out  8  FIFO write byte (combinational).
busy  out  1  a frame is in flight (state != IDLE).
drop_count  out  CNT_WIDTH  samples dropped, saturating.
frame_count  out  CNT_WIDTH  completed frames of all kinds, wrapping.

Behaviour:
- Reset values: state IDLE; hold_valid, sync_pending, status_pending = 0; sample_cnt = 0; drop_count = 0; frame_count = 0; fifo_wr_en = 0; fifo_wr_data = 0.
- Sample hold register (1 deep):
  - sample_valid with the hold empty, or the hold being consumed this cycle, loads the hold.
  - sample_valid with the hold occupied and not being consumed drops the sample and increments drop_count, saturating at all-ones.
  - Samples are accepted even when enable = 0.
- Sync scheduling:
  - sample_cnt increments on every accepted sample.
  - If an accepted sample finds sample_cnt == SYNC_PERIOD-1, sample_cnt wraps to 0 and sync_pending is set.
  - The sync frame is therefore emitted before the sample that triggered it.
- Status scheduling:
  - status_req sets status_pending.
  - A repeat status_req while pending is merged into the single pending request.
  - The status payload is captured at frame start: {STATUS_TAG, drop_count[15:0]}. With CNT_WIDTH > 16 the lower 16 bits are used.
- FSM states: IDLE, BYTE0, BYTE1, BYTE2.
  - IDLE with enable = 1 selects a source by fixed priority: sync_pending > status_pending > hold_valid.
  - On selection: load the 24-bit frame register, clear the selected pending or valid flag, go to BYTE0.
  - IDLE with nothing pending, or enable = 0, stays in IDLE.
  - In BYTEn: fifo_wr_en = !fifo_full; fifo_wr_data = frame[8n+7:8n].
  - If fifo_full: stall in the current state with wr_en = 0. Stalls are unbounded.
  - BYTE0 -> BYTE1 -> BYTE2 advance only on a cycle where a write occurs.
  - BYTE2 write: frame_count++, go to IDLE.
  - Minimum frame time is 4 cycles (IDLE select + 3 writes).
  - In IDLE, fifo_wr_en = 0 and fifo_wr_data holds its last value.
- Latency: sample_valid at cycle t -> hold at t+1 -> selected at t+1 if IDLE -> byte0 written at t+2 (FIFO not full).
- enable deasserted mid-frame: the frame completes; no new selection is made. Pending flags and counters are retained.
- Reset mid-frame: the partial frame is abandoned and all state cleared. The FIFO shares rst_n, so no partial frame survives.
- Simultaneous events in one cycle:
  - sample_valid and status_req: both are recorded.
  - sample_valid while IDLE selects the hold: the new sample loads the hold and is not dropped.

Decomposition:
- Package audio_stream_pkg holds:
  - frame_state_t enum (IDLE, BYTE0, BYTE1, BYTE2);
  - frame_src_t enum (SRC_SYNC, SRC_STATUS, SRC_SAMPLE);
  - default SYNC_WORD and STATUS_TAG constants;
  - FRAME_BYTES = 3.
- One natural sub-module: frame_src_arbiter, a combinational fixed-priority select over the three request flags returning frame_src_t and a grant.

Test Plan:
- Single sample 24'h123456, fifo_full = 0 -> writes 56, 34, 12 on cycles t+2..t+4; frame_count = 1; busy high for 3 cycles.
- SYNC_PERIOD = 4, 8 samples spaced 10 cycles apart -> byte stream S0 S1 S2 SYNC S3 S4 S5 S6 SYNC S7; each SYNC written as 00, FF, AA.
- fifo_full held high for 20 cycles after byte1 of sample 24'hABCDEF -> no wr_en during the stall; then EF already written, CD, AB follow; no byte is duplicated.
- fifo_full held high while 3 samples arrive back-to-back -> one sample in flight, one held, one dropped; drop_count = 1; after release exactly 2 frames appear.
- status_req in the same cycle as sample_valid, with drop_count = 16'h0003 -> status frame 03, 00, 5A precedes the sample frame.
- enable = 0 asserted during BYTE1, then rst_n pulsed low mid-frame in a second run -> first run: the frame completes, then no further writes; after reset: all outputs and counters are 0.

Source files
------------

// File: rtl/audio_stream_pkg.sv
// ---------------------------------------------------------------------------
// audio_stream_pkg
// Shared types and constants for the tx FIFO frame scheduler.
//   frame_state_t : byte-serialiser states (IDLE, then one state per byte)
//   frame_src_t   : which source a frame is built from
//   DEFAULT_*     : default sync payload and status tag
//   FRAME_BYTES   : bytes per frame, written LSB first
// ---------------------------------------------------------------------------
package audio_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BYTE0 = 2'd1,
    BYTE1 = 2'd2,
    BYTE2 = 2'd3
  } frame_state_t;

  typedef enum logic [1:0] {
    SRC_SYNC   = 2'd0,
    SRC_STATUS = 2'd1,
    SRC_SAMPLE = 2'd2
  } frame_src_t;

  localparam logic [23:0] DEFAULT_SYNC_WORD  = 24'hAAFF00;
  localparam logic [7:0]  DEFAULT_STATUS_TAG = 8'h5A;
  localparam int          FRAME_BYTES        = 3;

  // Byte of the frame register that belongs to a given BYTEn state.
  function automatic logic [7:0] frame_byte(input logic [23:0] frame,
                                            input frame_state_t st);
    logic [7:0] b;
    case (st)
      BYTE1:   b = frame[15:8];
      BYTE2:   b = frame[23:16];
      default: b = frame[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/frame_src_arbiter.sv
// ---------------------------------------------------------------------------
// frame_src_arbiter
// Combinational fixed-priority select: sync > status > sample.
//   sync_req_i   : a sync frame is pending
//   status_req_i : a status frame is pending
//   sample_req_i : the sample hold register is occupied
//   src_o        : selected source (only meaningful when grant_o = 1)
//   grant_o      : at least one source is requesting
// ---------------------------------------------------------------------------
module frame_src_arbiter
  import audio_stream_pkg::*;
(
  input  logic       sync_req_i,
  input  logic       status_req_i,
  input  logic       sample_req_i,
  output frame_src_t src_o,
  output logic       grant_o
);

  // NOTE: every output gets a default before the priority chain so no path
  // leaves it unassigned; otherwise a latch is inferred.
  always_comb begin
    src_o   = SRC_SAMPLE;
    grant_o = sync_req_i | status_req_i | sample_req_i;
    if (sync_req_i) begin
      src_o = SRC_SYNC;
    end else if (status_req_i) begin
      src_o = SRC_STATUS;
    end
  end

endmodule

// File: rtl/audio_fifo_scheduler.sv
// ---------------------------------------------------------------------------
// audio_fifo_scheduler
// Shares the byte-wide tx FIFO write port between audio samples, periodic
// sync markers and on-demand status frames. Each frame is 3 bytes, LSB first,
// never interleaved. Stalls on fifo_full; counts dropped samples.
//   clk, rst_n     : clock, synchronous active-low reset
//   enable         : 1 = new frames may start; 0 = finish current, then idle
//   sample_valid   : one-cycle pulse qualifying sample_data[23:0]
//   status_req     : one-cycle pulse requesting a status frame
//   fifo_full      : FIFO full flag
//   fifo_wr_en     : FIFO write strobe (combinational)
//   fifo_wr_data   : FIFO write byte (combinational, holds value in IDLE)
//   busy           : a frame is in flight
//   drop_count     : samples dropped, saturating
//   frame_count    : completed frames of all kinds, wrapping
// ---------------------------------------------------------------------------
module audio_fifo_scheduler
  import audio_stream_pkg::*;
#(
  parameter int unsigned SYNC_PERIOD = 126,
  parameter logic [23:0] SYNC_WORD   = DEFAULT_SYNC_WORD,
  parameter logic [7:0]  STATUS_TAG  = DEFAULT_STATUS_TAG,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 sample_valid,
  input  logic [23:0]          sample_data,
  input  logic                 status_req,
  input  logic                 fifo_full,
  output logic                 fifo_wr_en,
  output logic [7:0]           fifo_wr_data,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] drop_count,
  output logic [CNT_WIDTH-1:0] frame_count
);

  localparam int unsigned SC_W = (SYNC_PERIOD > 2) ? $clog2(SYNC_PERIOD) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SYNC_PERIOD - 1);

  frame_state_t          state_q, state_d;
  logic [23:0]           frame_q, frame_d;
  logic [23:0]           hold_q, hold_d;
  logic                  hold_valid_q, hold_valid_d;
  logic                  sync_pending_q, sync_pending_d;
  logic                  status_pending_q, status_pending_d;
  logic [SC_W-1:0]       sample_cnt_q, sample_cnt_d;
  logic [CNT_WIDTH-1:0]  drop_count_q, drop_count_d;
  logic [CNT_WIDTH-1:0]  frame_count_q, frame_count_d;
  logic [7:0]            last_data_q, last_data_d;

  frame_src_t            src;
  logic                  grant;
  logic                  select;
  logic                  consume_hold;

  frame_src_arbiter u_arbiter (
    .sync_req_i   (sync_pending_q),
    .status_req_i (status_pending_q),
    .sample_req_i (hold_valid_q),
    .src_o        (src),
    .grant_o      (grant)
  );

  assign select       = (state_q == IDLE) && enable && grant;
  assign consume_hold = select && (src == SRC_SAMPLE);

  // Frame serialiser: selection in IDLE, one byte per successful write.
  always_comb begin
    state_d          = state_q;
    frame_d          = frame_q;
    frame_count_d    = frame_count_q;
    sync_pending_d   = sync_pending_q;
    status_pending_d = status_pending_q;
    hold_valid_d     = hold_valid_q;
    fifo_wr_en       = 1'b0;
    fifo_wr_data     = last_data_q;

    case (state_q)
      IDLE: begin
        if (select) begin
          state_d = BYTE0;
          case (src)
            SRC_SYNC: begin
              frame_d        = SYNC_WORD;
              sync_pending_d = 1'b0;
            end
            SRC_STATUS: begin
              frame_d          = {STATUS_TAG, 16'(drop_count_q)};
              status_pending_d = 1'b0;
            end
            default: begin
              frame_d      = hold_q;
              hold_valid_d = 1'b0;
            end
          endcase
        end
      end
      BYTE0, BYTE1, BYTE2: begin
        fifo_wr_en   = !fifo_full;
        fifo_wr_data = frame_byte(frame_q, state_q);
        if (!fifo_full) begin
          case (state_q)
            BYTE0:   state_d = BYTE1;
            BYTE1:   state_d = BYTE2;
            default: begin
              state_d       = IDLE;
              frame_count_d = frame_count_q + CNT_WIDTH'(1);
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase

    // A new request in the cycle its flag is being cleared must survive.
    if (status_req) begin
      status_pending_d = 1'b1;
    end
  end

  // Sample hold, sync scheduling and drop accounting.
  always_comb begin
    hold_d       = hold_q;
    sample_cnt_d = sample_cnt_q;
    drop_count_d = drop_count_q;
    if (sample_valid) begin
      if (!hold_valid_q || consume_hold) begin
        hold_d = sample_data;
        if (sample_cnt_q == SC_LAST) begin
          sample_cnt_d = '0;
        end else begin
          sample_cnt_d = sample_cnt_q + SC_W'(1);
        end
      end else if (drop_count_q != '1) begin
        drop_count_d = drop_count_q + CNT_WIDTH'(1);
      end
    end
  end

  logic accept;
  assign accept = sample_valid && (!hold_valid_q || consume_hold);

  assign last_data_d = fifo_wr_data;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      hold_valid_q     <= 1'b0;
      sync_pending_q   <= 1'b0;
      status_pending_q <= 1'b0;
      sample_cnt_q     <= '0;
      drop_count_q     <= '0;
      frame_count_q    <= '0;
      last_data_q      <= '0;
    end else begin
      state_q          <= state_d;
      hold_valid_q     <= accept ? 1'b1 : hold_valid_d;
      sync_pending_q   <= (accept && (sample_cnt_q == SC_LAST)) ? 1'b1 : sync_pending_d;
      status_pending_q <= status_pending_d;
      sample_cnt_q     <= sample_cnt_d;
      drop_count_q     <= drop_count_d;
      frame_count_q    <= frame_count_d;
      last_data_q      <= last_data_d;
    end
  end

  // NOTE: payload registers carry no reset; their contents are only used
  // after a valid flag or a frame selection has loaded them.
  always_ff @(posedge clk) begin
    hold_q  <= hold_d;
    frame_q <= frame_d;
  end

  assign busy        = (state_q != IDLE);
  assign drop_count  = drop_count_q;
  assign frame_count = frame_count_q;

endmodule
